// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR timeout scheduler.
// Holds the FSM state encoding and the 4-bit maximal-length LFSR step function.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_TERM    = 4'hF;
  localparam logic [LFSR_W-1:0] LFSR_ILLEGAL = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  // x^4 + x^3 + 1 Fibonacci form; all-zero is the lock-up state and is never entered.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/lfsr_timer_sched_if.sv
// Request/grant/completion bundle between client FSMs and the LFSR timeout scheduler.
// Clients use the master view; the scheduler uses the slave view.
interface lfsr_timer_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_seed;
  logic                 abort;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic                 busy;
  logic [ID_W-1:0]      cur_id;

  modport master (
    output req, req_seed, abort,
    input  gnt, done, err, busy, cur_id
  );

  modport slave (
    input  req, req_seed, abort,
    output gnt, done, err, busy, cur_id
  );

endinterface

// File: rtl/lfsr4_core.sv
// 4-bit LFSR register with synchronous reset to the terminal state.
// A load takes priority over a step in the same cycle.
module lfsr4_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= LFSR_TERM;
    end else if (load) begin
      q_reg <= seed;
    end else if (step) begin
      q_reg <= lfsr_next(q_reg);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/lfsr_timer_sched.sv
// Round-robin scheduler sharing one 4-bit LFSR terminal counter among NUM_REQ clients.
// A granted client's seed is loaded and stepped until 4'hF, then done is pulsed to it.
module lfsr_timer_sched
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  lfsr_timer_sched_if.slave bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [LFSR_W-1:0] seed_reg, seed_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic [ID_W-1:0]   cur_id_reg, cur_id_next;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;

  logic [LFSR_W-1:0] seed_arr [NUM_REQ];
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  int                pick_idx;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
    return (i == LAST_ID) ? '0 : i + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_seed
      assign seed_arr[gi] = bus.req_seed[gi*LFSR_W +: LFSR_W];
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping; the owner of the last job goes to the back.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_idx = int'(rr_ptr_reg) + i;
      if (pick_idx >= NUM_REQ) pick_idx = pick_idx - NUM_REQ;
      if (!pick_found && bus.req[ID_W'(pick_idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(pick_idx);
      end
    end
  end

  lfsr4_core u_core (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed_reg),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    seed_next   = seed_reg;
    rr_ptr_next = rr_ptr_reg;
    gnt_next    = '0;
    done_next   = '0;
    err_next    = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    // Output pulses are set on the transition so they are high during the target state.
    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next        = LOAD;
          id_next           = pick_id;
          seed_next         = seed_arr[pick_id];
          gnt_next[pick_id] = 1'b1;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_next  = IDLE;
          rr_ptr_next = next_id(id_reg);
        end else if (seed_reg == LFSR_ILLEGAL) begin
          // Zero would lock the LFSR, so it is reported instead of loaded.
          state_next       = DONE;
          done_next[id_reg] = 1'b1;
          err_next         = 1'b1;
        end else begin
          state_next = COUNT;
          lfsr_load  = 1'b1;
        end
      end
      COUNT: begin
        if (bus.abort) begin
          state_next  = IDLE;
          rr_ptr_next = next_id(id_reg);
        end else if (lfsr_q == LFSR_TERM) begin
          state_next        = DONE;
          done_next[id_reg] = 1'b1;
        end else begin
          lfsr_step = 1'b1;
        end
      end
      DONE: begin
        state_next  = IDLE;
        rr_ptr_next = next_id(id_reg);
      end
      default: state_next = IDLE;
    endcase

    busy_next   = (state_next != IDLE);
    cur_id_next = (state_next != IDLE) ? id_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      id_reg     <= '0;
      seed_reg   <= '0;
      rr_ptr_reg <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      cur_id_reg <= '0;
    end else begin
      state_reg  <= state_next;
      id_reg     <= id_next;
      seed_reg   <= seed_next;
      rr_ptr_reg <= rr_ptr_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      busy_reg   <= busy_next;
      cur_id_reg <= cur_id_next;
    end
  end

  assign bus.gnt    = gnt_reg;
  assign bus.done   = done_reg;
  assign bus.err    = err_reg;
  assign bus.busy   = busy_reg;
  assign bus.cur_id = cur_id_reg;

endmodule

// File: tb/tb_lfsr_timer_sched.sv
// Directed bench for lfsr_timer_sched: latencies, round-robin order, illegal seed, abort, reset.
// Expected step counts come from the hand-walked LFSR cycle F,E,C,8,1,2,4,9,3,6,D,A,5,B,7.
module tb_lfsr_timer_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lfsr_timer_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  lfsr_timer_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},   32'(bus.busy),   32'h0);
    check({tag, ".gnt"},    32'(bus.gnt),    32'h0);
    check({tag, ".done"},   32'(bus.done),   32'h0);
    check({tag, ".err"},    32'(bus.err),    32'h0);
    check({tag, ".cur_id"}, 32'(bus.cur_id), 32'h0);
  endtask

  // Single requester from IDLE; done expected k+3 cycles after the request (2 for seed 0).
  task automatic run_job(input int id, input logic [3:0] seed, input int k, input logic exp_err);
    logic [3:0] oh;
    int last;
    oh   = 4'b0001 << id;
    last = (seed == 4'h0) ? 2 : 3 + k;
    bus.req_seed[id*4 +: 4] = seed;
    bus.req = oh;
    for (int c = 1; c <= last; c++) begin
      tick();
      check("job.gnt",    32'(bus.gnt),    (c == 1) ? 32'(oh) : 32'h0);
      check("job.done",   32'(bus.done),   (c == last) ? 32'(oh) : 32'h0);
      check("job.err",    32'(bus.err),    (c == last) ? 32'(exp_err) : 32'h0);
      check("job.busy",   32'(bus.busy),   32'h1);
      check("job.cur_id", 32'(bus.cur_id), 32'(id));
      if (c == 1) bus.req = '0;
    end
    tick();
    check_idle("job.after");
    $display("job id=%0d seed=%h k=%0d err=%0b done_at=T+%0d", id, seed, k, exp_err, last);
  endtask

  initial begin
    logic [3:0] oh;
    bus.req      = '0;
    bus.req_seed = '0;
    bus.abort    = 1'b0;

    // Power-on reset.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle("reset");
    check("reset.lfsr", 32'(dut.lfsr_q), 32'hF);
    $display("reset: outputs idle, lfsr=%h", dut.lfsr_q);

    // All four requesting with terminal seeds: grants rotate 0,1,2,3,0.
    bus.req_seed = 16'hFFFF;
    bus.req      = 4'hF;
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << (j % 4);
      for (int c = 1; c <= 4; c++) begin
        tick();
        check("rr.gnt",  32'(bus.gnt),  (c == 1) ? 32'(oh) : 32'h0);
        check("rr.done", 32'(bus.done), (c == 3) ? 32'(oh) : 32'h0);
        check("rr.busy", 32'(bus.busy), (c != 4) ? 32'h1 : 32'h0);
        if (c <= 3) check("rr.cur_id", 32'(bus.cur_id), 32'(j % 4));
        if (j == 4 && c == 3) bus.req = '0;
      end
      $display("rr job %0d: gnt=%b", j, oh);
    end
    tick();
    check_idle("rr.after");

    // Latency cases and the illegal zero seed.
    bus.req_seed = '0;
    run_job(0, 4'h7, 1, 1'b0);
    run_job(0, 4'hE, 14, 1'b0);
    run_job(0, 4'hF, 0, 1'b0);
    run_job(1, 4'h0, 0, 1'b1);
    run_job(3, 4'h5, 3, 1'b0);
    run_job(2, 4'h1, 11, 1'b0);
    run_job(3, 4'hA, 4, 1'b0);

    // Abort mid-COUNT; the other pending requester is served next.
    bus.req_seed = '0;
    bus.req_seed[3:0] = 4'hE;
    bus.req_seed[7:4] = 4'hF;
    bus.req = 4'b0011;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("abort.gnt",  32'(bus.gnt),  (c == 1) ? 32'h1 : 32'h0);
      check("abort.done", 32'(bus.done), 32'h0);
      check("abort.busy", 32'(bus.busy), 32'h1);
      if (c == 1) bus.req[0] = 1'b0;
    end
    check("abort.lfsr", 32'(dut.lfsr_q), 32'h1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle("abort.idle");
    tick();
    check("abort.gnt1",   32'(bus.gnt),    32'h2);
    check("abort.cur_id", 32'(bus.cur_id), 32'h1);
    bus.req = '0;
    tick();
    check("abort.done1a", 32'(bus.done), 32'h0);
    tick();
    check("abort.done1b", 32'(bus.done), 32'h2);
    tick();
    check_idle("abort.after");
    $display("abort: job 0 dropped, job 1 granted next");

    // Reset in the middle of a count drops the job and clears the round-robin pointer.
    bus.req_seed[11:8] = 4'hE;
    bus.req = 4'b0100;
    tick();
    check("rstmid.gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    repeat (3) tick();
    check("rstmid.busy_pre", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle("rstmid");
    check("rstmid.lfsr", 32'(dut.lfsr_q), 32'hF);
    for (int c = 0; c < 15; c++) begin
      tick();
      check("rstmid.nodone", 32'(bus.done), 32'h0);
    end
    bus.req_seed = 16'h0F0F;
    bus.req = 4'b0101;
    tick();
    check("rstmid.gnt0", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    tick();
    tick();
    check("rstmid.done0", 32'(bus.done), 32'h1);
    tick();
    tick();
    check("rstmid.gnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();
    tick();
    check("rstmid.done2", 32'(bus.done), 32'h4);
    tick();
    check_idle("rstmid.after");
    $display("reset mid-job: dropped, pointer back to 0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
